// File: rtl/mc_control_fsm_if.sv
// Control bus between the multi-cycle control FSM and the CPU datapath.
// The FSM (master) receives the decoded IR fields and datapath status,
// and drives the write-enables, PC selects and ALU controls.
interface mc_control_fsm_if;
    // datapath -> FSM
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    // FSM -> datapath
    logic       ir_we;
    logic       pc_we;
    logic       jump;
    logic       beq;
    logic       bne;
    logic       regorimm;
    logic       reg_we;
    logic [1:0] regdst;
    logic [1:0] wb_src;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_we;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output ir_we, pc_we, jump, beq, bne, regorimm,
        output reg_we, regdst, wb_src, alu_src, alu_op, mem_we
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  ir_we, pc_we, jump, beq, bne, regorimm,
        input  reg_we, regdst, wb_src, alu_src, alu_op, mem_we
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// write-enables, PC selects, ALU op and a retired-instruction counter.
// Optional build macro MEM_WAIT_EN: MEM stalls until mem_ready is high.
// Without it mem_ready is ignored and MEM always lasts one cycle.
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    mc_control_fsm_if.master bus,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_LW, I_SW, I_RALU, I_ADDI, I_XORI,
        I_BEQ, I_BNE, I_J, I_JR, I_JAL, I_ILL
    } instr_t;

    // One cycle's worth of datapath control
    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic       jump;
        logic       beq;
        logic       bne;
        logic       regorimm;
        logic       reg_we;
        logic [1:0] regdst;
        logic [1:0] wb_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_we;
        logic       illegal;
    } ctrl_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_XOR = 2'd2;
    localparam logic [1:0] ALU_SLT = 2'd3;

    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    instr_t            kind;
    logic [1:0]        r_alu_op;
    logic              mem_ok;
    ctrl_t             ctrl;

`ifdef MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    // Classify the IR into one instruction kind; anything unrecognised is illegal
    always_comb begin
        kind     = I_ILL;
        r_alu_op = ALU_ADD;
        case (bus.opcode)
            OP_R: begin
                case (bus.funct)
                    FN_ADD:  begin kind = I_RALU; r_alu_op = ALU_ADD; end
                    FN_SUB:  begin kind = I_RALU; r_alu_op = ALU_SUB; end
                    FN_SLT:  begin kind = I_RALU; r_alu_op = ALU_SLT; end
                    FN_JR:   kind = I_JR;
                    default: kind = I_ILL;
                endcase
            end
            OP_J:    kind = I_J;
            OP_JAL:  kind = I_JAL;
            OP_BEQ:  kind = I_BEQ;
            OP_BNE:  kind = I_BNE;
            OP_ADDI: kind = I_ADDI;
            OP_XORI: kind = I_XORI;
            OP_LW:   kind = I_LW;
            OP_SW:   kind = I_SW;
            default: kind = I_ILL;
        endcase
    end

    // Next-state and Moore/Mealy control decode; reset masks every write
    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_we = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                case (kind)
                    I_J: begin
                        ctrl.pc_we = 1'b1;
                        ctrl.jump  = 1'b1;
                    end
                    I_JR: begin
                        ctrl.pc_we    = 1'b1;
                        ctrl.jump     = 1'b1;
                        ctrl.regorimm = 1'b1;
                    end
                    I_JAL:   state_d = S_WB;
                    I_ILL: begin
                        // skip to PC+4: all selects stay 0
                        ctrl.illegal = 1'b1;
                        ctrl.pc_we   = 1'b1;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (kind)
                    I_LW, I_SW: begin
                        ctrl.alu_src = 1'b1;
                        ctrl.alu_op  = ALU_ADD;
                        state_d      = S_MEM;
                    end
                    I_RALU: begin
                        ctrl.alu_op = r_alu_op;
                        state_d     = S_WB;
                    end
                    I_ADDI: begin
                        ctrl.alu_src = 1'b1;
                        ctrl.alu_op  = ALU_ADD;
                        state_d      = S_WB;
                    end
                    I_XORI: begin
                        ctrl.alu_src = 1'b1;
                        ctrl.alu_op  = ALU_XOR;
                        state_d      = S_WB;
                    end
                    I_BEQ: begin
                        ctrl.alu_op = ALU_SUB;
                        ctrl.pc_we  = 1'b1;
                        ctrl.beq    = bus.zero;
                    end
                    I_BNE: begin
                        ctrl.alu_op = ALU_SUB;
                        ctrl.pc_we  = 1'b1;
                        ctrl.bne    = ~bus.zero;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                case (kind)
                    I_LW: begin
                        if (mem_ok) state_d = S_WB;
                    end
                    I_SW: begin
                        // store stays asserted through any wait; commit on ready
                        ctrl.mem_we = 1'b1;
                        ctrl.pc_we  = mem_ok;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_WB: begin
                case (kind)
                    I_LW: begin
                        ctrl.reg_we = 1'b1;
                        ctrl.regdst = DST_RT;
                        ctrl.wb_src = WB_MEM;
                        ctrl.pc_we  = 1'b1;
                    end
                    I_RALU: begin
                        ctrl.reg_we = 1'b1;
                        ctrl.regdst = DST_RD;
                        ctrl.wb_src = WB_ALU;
                        ctrl.pc_we  = 1'b1;
                    end
                    I_ADDI, I_XORI: begin
                        ctrl.reg_we = 1'b1;
                        ctrl.regdst = DST_RT;
                        ctrl.wb_src = WB_ALU;
                        ctrl.pc_we  = 1'b1;
                    end
                    I_JAL: begin
                        ctrl.reg_we = 1'b1;
                        ctrl.regdst = DST_R31;
                        ctrl.wb_src = WB_PC4;
                        ctrl.pc_we  = 1'b1;
                        ctrl.jump   = 1'b1;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            default: state_d = S_FETCH;
        endcase

        // every commit ends the instruction
        if (ctrl.pc_we) state_d = S_FETCH;

        // abort: no writes in the reset cycle, only the IR load if already in FETCH
        if (reset) begin
            state_d    = S_FETCH;
            ctrl       = '0;
            ctrl.ir_we = (state_q == S_FETCH);
        end
    end

    // Retired counter advances once per commit and wraps naturally
    always_comb begin
        retired_d = retired_q + CNT_W'(ctrl.pc_we);
        if (reset) retired_d = '0;
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        retired_q <= retired_d;
    end

    assign bus.ir_we    = ctrl.ir_we;
    assign bus.pc_we    = ctrl.pc_we;
    assign bus.jump     = ctrl.jump;
    assign bus.beq      = ctrl.beq;
    assign bus.bne      = ctrl.bne;
    assign bus.regorimm = ctrl.regorimm;
    assign bus.reg_we   = ctrl.reg_we;
    assign bus.regdst   = ctrl.regdst;
    assign bus.wb_src   = ctrl.wb_src;
    assign bus.alu_src  = ctrl.alu_src;
    assign bus.alu_op   = ctrl.alu_op;
    assign bus.mem_we   = ctrl.mem_we;
    assign illegal      = ctrl.illegal;
    assign state        = state_q;
    assign retired      = retired_q;

endmodule
